// File: rtl/alu_result_stage_if.sv
// ============================================================================
// Module      : alu_result_stage_if
// Description : Handshake bundle between the ALU, the result stage and the
//               writeback consumer. ovf_count exists only with ALU_OVF_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_G;
    logic             in_Cout;
    logic             in_V;
    logic [2:0]       in_S;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_G;
    logic [3:0]       out_flags;
    logic [3:0]       status;
`ifdef ALU_OVF_COUNT_EN
    logic [15:0]      ovf_count;
`endif

    modport slave (
        input  in_valid, in_G, in_Cout, in_V, in_S, out_ready,
        output in_ready, out_valid, out_G, out_flags, status
`ifdef ALU_OVF_COUNT_EN
        , output ovf_count
`endif
    );

    modport master (
        output in_valid, in_G, in_Cout, in_V, in_S, out_ready,
        input  in_ready, out_valid, out_G, out_flags, status
`ifdef ALU_OVF_COUNT_EN
        , input ovf_count
`endif
    );
endinterface

`default_nettype wire

// File: rtl/alu_result_stage.sv
// ============================================================================
// Module      : alu_result_stage
// Description : Registered ALU result stage with 2-entry skid buffer, N/Z/C/V
//               flag derivation and retire status. Optional overflow retire
//               counter enabled by macro ALU_OVF_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    alu_result_stage_if.slave  bus
);
    logic [WIDTH-1:0] r_main_g;
    logic [3:0]       r_main_f;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_g;
    logic [3:0]       r_skid_f;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [3:0]       r_status;

    logic             w_accept;
    logic             w_retire;
    logic [3:0]       w_in_flags;
    logic             w_logic_op;

    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_retire   = r_main_valid & bus.out_ready;
    assign w_logic_op = bus.in_S[2];

    // Logic ops carry no meaningful carry/overflow, so they are forced clear.
    assign w_in_flags = {bus.in_G[WIDTH-1],
                         (bus.in_G == '0),
                         bus.in_Cout & ~w_logic_op,
                         bus.in_V    & ~w_logic_op};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_g     <= '0;
            r_main_f     <= '0;
            r_main_valid <= 1'b0;
            r_skid_g     <= '0;
            r_skid_f     <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_status     <= '0;
        end else begin
            if (!r_main_valid || w_retire) begin
                if (r_skid_valid) begin
                    r_main_g     <= r_skid_g;
                    r_main_f     <= r_skid_f;
                    r_main_valid <= 1'b1;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_accept) begin
                    r_main_g     <= bus.in_G;
                    r_main_f     <= w_in_flags;
                    r_main_valid <= 1'b1;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                // Main is stalled: park the new result and close the input.
                r_skid_g     <= bus.in_G;
                r_skid_f     <= w_in_flags;
                r_skid_valid <= 1'b1;
                r_in_ready   <= 1'b0;
            end

            if (w_retire) begin
                r_status <= r_main_f;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.out_G     = r_main_g;
    assign bus.out_flags = r_main_f;
    assign bus.status    = r_status;

`ifdef ALU_OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (w_retire && r_main_f[0] && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign bus.ovf_count = r_ovf_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_result_stage.sv
// ============================================================================
// Module      : tb_alu_result_stage
// Description : Self-checking bench: queue-based reference model plus directed
//               literal checks and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(32)) bus ();

    alu_result_stage #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] g;
        logic [3:0]  f;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  m_status;
    int unsigned m_ovf;
    int          total = 0;
    int          bad   = 0;
    bit          checking = 1'b0;

    function automatic logic [3:0] flags_of(logic [31:0] g, logic cout, logic v, logic [2:0] s);
        logic [3:0] f;
        f[3] = g[31];
        f[2] = (g == 32'd0);
        f[1] = s[2] ? 1'b0 : cout;
        f[0] = s[2] ? 1'b0 : v;
        return f;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries.
    always @(posedge clk) begin
        bit acc;
        bit ret;
        if (rst) begin
            q.delete();
            m_status = 4'd0;
            m_ovf    = 0;
        end else begin
            acc = bus.in_valid && (q.size() < 2);
            ret = (q.size() > 0) && bus.out_ready;
            if (ret) begin
                m_status = q[0].f;
                if (q[0].f[0] && m_ovf < 65535) m_ovf++;
                void'(q.pop_front());
            end
            if (acc) q.push_back({bus.in_G, flags_of(bus.in_G, bus.in_Cout, bus.in_V, bus.in_S)});
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_G",     bus.out_G,          q[0].g);
                chk("out_flags", 32'(bus.out_flags), 32'(q[0].f));
            end
            chk("status", 32'(bus.status), 32'(m_status));
`ifdef ALU_OVF_COUNT_EN
            chk("ovf_count", 32'(bus.ovf_count), m_ovf);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [31:0] g, logic cout, logic ov, logic [2:0] s);
        bus.in_valid = v;
        bus.in_G     = g;
        bus.in_Cout  = cout;
        bus.in_V     = ov;
        bus.in_S     = s;
    endtask

    initial begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b000);
        step();
        checking = 1'b1;
        step();
        @(negedge clk);
        chk("rst_out_G",     bus.out_G,          32'd0);
        chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 3'b000);

        // Zero arithmetic result with carry.
        bus.out_ready = 1'b1;
        drive(1'b1, 32'd0, 1'b1, 1'b0, 3'b000);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_flags", 32'(bus.out_flags), 32'(4'b0110));
        step();
        @(negedge clk);
        chk("t1_status", 32'(bus.status), 32'(4'b0110));

        // Logic op clears C and V.
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b1, 3'b100);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t2_flags", 32'(bus.out_flags), 32'(4'b1000));
        step();

        // Back-pressure: A to main, B to skid, C refused.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_00AA, 1'b0, 1'b0, 3'b001);
        step();
        drive(1'b1, 32'h0000_00BB, 1'b0, 1'b0, 3'b001);
        step();
        @(negedge clk);
        chk("t3_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h0000_00CC, 1'b0, 1'b0, 3'b001);
        step();
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("t3_head_A", bus.out_G, 32'h0000_00AA);
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("t3_head_B", bus.out_G, 32'h0000_00BB);
        step();
        @(negedge clk);
        chk("t3_drained", 32'(bus.out_valid), 32'd0);

        // Full-throughput streaming.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, 1'($urandom), 1'($urandom), 3'($urandom));
            step();
            @(negedge clk);
            chk("t4_out_valid", 32'(bus.out_valid), 32'd1);
            chk("t4_in_ready",  32'(bus.in_ready),  32'd1);
        end
        bus.in_valid = 1'b0;
        step();

        // Reset while both entries are occupied.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h1111_1111, 1'b1, 1'b1, 3'b000);
        step();
        drive(1'b1, 32'h2222_2222, 1'b1, 1'b1, 3'b000);
        step();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t5_status",    32'(bus.status),    32'd0);
        bus.out_ready = 1'b1;
        repeat (3) step();

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                  1'($urandom), 1'($urandom), 3'($urandom));
            bus.out_ready = ($urandom_range(0, 9) < 6);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();

`ifdef ALU_OVF_COUNT_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h5 + 32'(i), 1'b0, (i < 3), 3'b010);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("t6_ovf3", 32'(bus.ovf_count), 32'd3);
        drive(1'b1, 32'h7, 1'b0, 1'b1, 3'b000);
        repeat (65540) step();
        bus.in_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("t6_ovf_sat", 32'(bus.ovf_count), 32'h0000_FFFF);
`endif

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
